wb_resp_mem: RTL and testbench

- Pipelined Wishbone (B4 pipelined) responder/memory model: the slave end that Wishbone initiators in the bench talk to.
- Holds a small word-addressed register array.
- Accepts one request per clock with byte-select writes.
- Returns ack/err after a fixed, parameterized latency; out-of-range addresses return bus errors.
- Used as the bus-side target in bench/verilog for exercising initiators and the SATA controller's DMA side.

---
 rtl/wb_resp_mem.sv | 126 ++++++++++++
 tb/tb_wb_resp_mem.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_resp_mem.sv
// wb_resp_mem -- pipelined Wishbone (B4) responder with a small word-addressed
// memory. Accepts one request per clock, byte-select writes, and answers each
// accepted request with ack (or err for out-of-range addresses) LATENCY
// cycles after acceptance, strictly in order.
//
// Optional build macro: WB_RESP_RANDSTALL_EN -- adds a 16-bit LFSR that
// pseudo-randomly asserts o_wb_stall while a cycle is open. Without it
// o_wb_stall is tied low.
//
// Ports:
//   i_clk, i_reset_n            clock, async active-low reset
//   i_wb_cyc, i_wb_stb, i_wb_we bus cycle, request strobe, write enable
//   i_wb_addr [AW]              word address
//   i_wb_data [DW], i_wb_sel    write data, byte selects
//   o_wb_stall                  request not accepted this cycle
//   o_wb_ack, o_wb_err          success / bus-error response (one-hot or idle)
//   o_wb_data [DW]              read data, nonzero only with a read ack
module wb_resp_mem #(
  parameter int          AW        = 5,
  parameter int          DW        = 32,
  parameter int          LATENCY   = 2,
  parameter int          MEMWORDS  = 24,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_wb_cyc,
  input  logic            i_wb_stb,
  input  logic            i_wb_we,
  input  logic [AW-1:0]   i_wb_addr,
  input  logic [DW-1:0]   i_wb_data,
  input  logic [DW/8-1:0] i_wb_sel,
  output logic            o_wb_stall,
  output logic            o_wb_ack,
  output logic [DW-1:0]   o_wb_data,
  output logic            o_wb_err
);

  localparam int SW = DW / 8;

  // Memory array has no reset; contents survive a bus reset.
  logic [DW-1:0] r_mem [MEMWORDS];

  // Response pipeline; stage LATENCY-1 is the registered output stage.
  logic [LATENCY-1:0] r_pv;
  logic [LATENCY-1:0] r_pe;
  logic [DW-1:0]      r_pd [LATENCY];

  logic          w_stall;
  logic          w_accept;
  logic          w_addr_ok;
  logic          w_flush;
  logic          w_head_v;
  logic [DW-1:0] w_rd_data;

`ifdef WB_RESP_RANDSTALL_EN
  logic [15:0] r_lfsr;
  logic        r_stall;
  logic        w_fb;

  // Fibonacci taps 16,14,13,11
  assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_lfsr  <= LFSR_SEED;
      r_stall <= 1'b0;
    end else if (i_wb_cyc) begin
      r_lfsr  <= {r_lfsr[14:0], w_fb};
      r_stall <= r_lfsr[0] & r_lfsr[3];
    end else begin
      r_stall <= 1'b0;
    end
  end

  assign w_stall = r_stall;
`else
  logic [15:0] w_unused_seed;
  assign w_unused_seed = LFSR_SEED;
  assign w_stall       = 1'b0;
`endif

  assign w_addr_ok = ({{(32-AW){1'b0}}, i_wb_addr} < MEMWORDS);
  assign w_accept  = i_wb_cyc & i_wb_stb & ~w_stall;
  assign w_rd_data = (w_addr_ok && !i_wb_we) ? r_mem[i_wb_addr] : '0;

  // Abandoned cycles and a presented error both discard everything in flight,
  // including a request accepted on the same edge.
  assign w_flush = ~i_wb_cyc | (r_pv[LATENCY-1] & r_pe[LATENCY-1]);

  // Writes are gated by i_reset_n so an edge that lands during reset never
  // commits a write.
  always_ff @(posedge i_clk) begin
    if (i_reset_n && w_accept && w_addr_ok && i_wb_we) begin
      for (int b = 0; b < SW; b++) begin
        if (i_wb_sel[b]) r_mem[i_wb_addr][8*b +: 8] <= i_wb_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pv <= '0;
      r_pe <= '0;
      for (int i = 0; i < LATENCY; i++) r_pd[i] <= '0;
    end else begin
      r_pv[0] <= w_accept & ~w_flush;
      r_pe[0] <= w_accept & ~w_addr_ok;
      r_pd[0] <= w_rd_data;
      for (int i = 1; i < LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1] & ~w_flush;
        r_pe[i] <= r_pe[i-1];
        r_pd[i] <= r_pd[i-1];
      end
    end
  end

  // Gating with i_wb_cyc keeps a response off the bus in the very cycle the
  // initiator abandons the cycle; the flush then clears it on the next edge.
  assign w_head_v   = r_pv[LATENCY-1] & i_wb_cyc;
  assign o_wb_ack   = w_head_v & ~r_pe[LATENCY-1];
  assign o_wb_err   = w_head_v &  r_pe[LATENCY-1];
  assign o_wb_data  = o_wb_ack ? r_pd[LATENCY-1] : '0;
  assign o_wb_stall = w_stall;

endmodule

// File: tb/tb_wb_resp_mem.sv
module tb_wb_resp_mem;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          i_clk = 1'b0;
  logic          i_reset_n = 1'b1;
  logic          i_wb_cyc = 1'b0;
  logic          i_wb_stb = 1'b0;
  logic          i_wb_we = 1'b0;
  logic [AW-1:0] i_wb_addr = '0;
  logic [DW-1:0] i_wb_data = '0;
  logic [3:0]    i_wb_sel = '0;
  logic          o_wb_stall;
  logic          o_wb_ack;
  logic [DW-1:0] o_wb_data;
  logic          o_wb_err;

  int n_checks = 0;
  int n_errors = 0;

  wb_resp_mem #(.AW(AW), .DW(DW), .LATENCY(2), .MEMWORDS(24)) u_dut (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_wb_cyc   (i_wb_cyc),
    .i_wb_stb   (i_wb_stb),
    .i_wb_we    (i_wb_we),
    .i_wb_addr  (i_wb_addr),
    .i_wb_data  (i_wb_data),
    .i_wb_sel   (i_wb_sel),
    .o_wb_stall (o_wb_stall),
    .o_wb_ack   (o_wb_ack),
    .o_wb_data  (o_wb_data),
    .o_wb_err   (o_wb_err)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic resp(input string tag, input logic ack, input logic err, input logic [31:0] data);
    check({tag, "_ack"},  o_wb_ack,  ack);
    check({tag, "_err"},  o_wb_err,  err);
    check({tag, "_data"}, o_wb_data, data);
  endtask

  // Present inputs for one clock, then sample 1ns after the edge.
  task automatic bus(input logic c, input logic s, input logic w, input logic [AW-1:0] a,
                     input logic [31:0] d, input logic [3:0] sl);
    i_wb_cyc  = c;
    i_wb_stb  = s;
    i_wb_we   = w;
    i_wb_addr = a;
    i_wb_data = d;
    i_wb_sel  = sl;
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    bus(1'b1, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    bus(1'b1, 1'b1, 1'b0, a, '0, '0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] sl);
    bus(1'b1, 1'b1, 1'b1, a, d, sl);
  endtask

`ifdef WB_RESP_RANDSTALL_EN
  logic [31:0] shadow [24];
  logic [31:0] exp_q [$];
  int n_acc = 0;
  int n_ack = 0;
  int n_stall = 0;

  task automatic tick();
    @(posedge i_clk);
    #1;
    if (o_wb_stall) n_stall++;
    check("rs_err", o_wb_err, 1'b0);
    if (o_wb_ack) begin
      n_ack++;
      if (exp_q.size() == 0) check("rs_extra_ack", o_wb_ack, 1'b0);
      else check("rs_data", o_wb_data, exp_q.pop_front());
    end
  endtask

  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] sl);
    int guard;
    logic acc;
    guard = 0;
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = w;
    i_wb_addr = a; i_wb_data = d; i_wb_sel = sl;
    forever begin
      acc = !o_wb_stall;
      if (acc) begin
        n_acc++;
        if (w) begin
          exp_q.push_back(32'h0);
          for (int b = 0; b < 4; b++) if (sl[b]) shadow[a][8*b +: 8] = d[8*b +: 8];
        end else begin
          exp_q.push_back(shadow[a]);
        end
      end
      tick();
      if (acc) break;
      guard++;
      if (guard > 200) begin
        check("rs_stall_timeout", 32'(guard), 32'd0);
        break;
      end
    end
    i_wb_stb = 1'b0;
  endtask
`endif

  initial begin
    #1 i_reset_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_stall", o_wb_stall, 1'b0);
    resp("rst", 1'b0, 1'b0, 32'h0);
    i_reset_n = 1'b1;
    bus(1'b0, 1'b0, 1'b0, '0, '0, '0);

    // Preload words 0..3, then a four-deep back-to-back read burst.
    for (int i = 0; i < 4; i++) wr(5'(i), 32'(10 + i), 4'hF);
    idle(); idle();
    rd(0); rd(1);
    resp("burst0", 1'b1, 1'b0, 32'd10);
    rd(2);
    resp("burst1", 1'b1, 1'b0, 32'd11);
    rd(3);
    resp("burst2", 1'b1, 1'b0, 32'd12);
    idle();
    resp("burst3", 1'b1, 1'b0, 32'd13);
    idle();
    resp("burst_end", 1'b0, 1'b0, 32'h0);

    // Full-word write then read back.
    wr(3, 32'hDEADBEEF, 4'hF);
    rd(3);
    resp("wr3", 1'b1, 1'b0, 32'h0);
    idle();
    resp("rd3", 1'b1, 1'b0, 32'hDEADBEEF);
    idle();
    resp("rd3_end", 1'b0, 1'b0, 32'h0);

    // Byte-select merge.
    wr(5, 32'hAABBCCDD, 4'hF);
    wr(5, 32'h11223344, 4'b0101);
    resp("w5a", 1'b1, 1'b0, 32'h0);
    rd(5);
    resp("w5b", 1'b1, 1'b0, 32'h0);
    idle();
    resp("rd5", 1'b1, 1'b0, 32'hAA22CC44);
    idle();

    // Out-of-range write followed by a pipelined read: err, then read dropped.
    wr(24, 32'h1, 4'hF);
    rd(0);
    resp("err24", 1'b0, 1'b1, 32'h0);
    idle();
    resp("err_flush", 1'b0, 1'b0, 32'h0);
    bus(1'b0, 1'b0, 1'b0, '0, '0, '0);
    bus(1'b0, 1'b0, 1'b0, '0, '0, '0);
    rd(0); idle();
    resp("w0_kept", 1'b1, 1'b0, 32'd10);
    rd(31); idle();
    resp("err31", 1'b0, 1'b1, 32'h0);
    bus(1'b0, 1'b0, 1'b0, '0, '0, '0);

    // Abort: drop cyc one cycle after the second accept; the strobe seen with
    // cyc low must not write.
    rd(1); rd(2);
    resp("abort_first", 1'b1, 1'b0, 32'd11);
    bus(1'b0, 1'b1, 1'b1, 5'd2, 32'hFFFFFFFF, 4'hF);
    resp("abort_a", 1'b0, 1'b0, 32'h0);
    bus(1'b0, 1'b0, 1'b0, '0, '0, '0);
    idle();
    resp("abort_c", 1'b0, 1'b0, 32'h0);
    rd(2); idle();
    resp("w2_kept", 1'b1, 1'b0, 32'd12);
    idle();

    // Reset asserted between edges with a response on the bus.
    wr(7, 32'h55, 4'hF);
    rd(3);
    resp("pre_rst", 1'b1, 1'b0, 32'h0);
    #2 i_reset_n = 1'b0;
    #1;
    resp("rst_mid", 1'b0, 1'b0, 32'h0);
    check("rst_mid_stall", o_wb_stall, 1'b0);
    wr(3, 32'h0, 4'hF);
    resp("rst_hold", 1'b0, 1'b0, 32'h0);
    i_reset_n = 1'b1;
    rd(7); rd(3);
    resp("rst_w7", 1'b1, 1'b0, 32'h55);
    idle();
    resp("rst_w3", 1'b1, 1'b0, 32'hDEADBEEF);
    idle();

`ifdef WB_RESP_RANDSTALL_EN
    for (int i = 0; i < 24; i++) issue(1'b1, 5'(i), $urandom, 4'hF);
    for (int i = 0; i < 100; i++)
      issue(1'($urandom_range(0, 1)), 5'($urandom_range(0, 23)), $urandom, 4'($urandom_range(0, 15)));
    i_wb_stb = 1'b0;
    repeat (4) tick();
    check("rs_ack_count", 32'(n_ack), 32'(n_acc));
    check("rs_stall_seen", 32'(n_stall > 0), 32'd1);
    i_wb_cyc = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
